// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store adapter:
// access size codes, dmem operation codes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] MEM_OP_READ  = 2'd0;
  localparam logic [1:0] MEM_OP_WRITE = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LOAD,
    ST_STORE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } lsu_state_t;

  // Size codes 2 and 3 both mean a full word.
  function automatic logic is_word(logic [1:0] sz);
    return sz[1];
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane extract (with sign/zero extension) and
// sub-word merge. Ports: word, wdata, off, size, sign -> ext, merged.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  logic [1:0]  bsel;
  logic        hsel;
  logic [7:0]  b;
  logic [15:0] h;
  logic [4:0]  sh;
  logic [31:0] mask;

  always_comb begin
    bsel   = BIG_ENDIAN ? ~off : off;
    hsel   = BIG_ENDIAN ? ~off[1] : off[1];
    b      = word[{bsel, 3'b000} +: 8];
    h      = word[{hsel, 4'b0000} +: 16];
    sh     = (size == SZ_BYTE) ? {bsel, 3'b000}
                               : {hsel, 4'b0000};
    mask   = ((size == SZ_BYTE) ? 32'h0000_00FF
                                : 32'h0000_FFFF) << sh;
    ext    = word;
    merged = wdata;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        ext    = {{24{sign & b[7]}}, b};
        merged = (word & ~mask) | ((wdata << sh) & mask);
      end
      (size == SZ_HALF): begin
        ext    = {{16{sign & h[15]}}, h};
        merged = (word & ~mask) | ((wdata << sh) & mask);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_adapter.sv
// MEM-stage load/store adapter onto a word-only dmem port (RMW for
// sub-word stores). Ports: io_req_*, io_resp_*, io_dmem_*.
module dmem_lsu_adapter
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [31:0]       io_req_wdata,
  input  logic              io_req_is_store,
  input  logic [1:0]        io_req_size,
  input  logic              io_req_sign_ext,
  output logic              io_resp_valid,
  output logic [31:0]       io_resp_data,
  output logic              io_resp_misaligned,
  output logic              io_dmem_request_valid,
  output logic [31:0]       io_dmem_request_bits_address,
  output logic [31:0]       io_dmem_request_bits_writedata,
  output logic [1:0]        io_dmem_request_bits_operation,
  input  logic              io_dmem_response_valid,
  input  logic [31:0]       io_dmem_response_bits_data
);

  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              store_q;
  logic              sign_q;

  logic [31:0] addr32;
  logic [31:0] ext;
  logic [31:0] merged;
  logic        misaligned;
  logic        done;

  assign addr32 = 32'(addr_q);
  assign io_req_ready = (state == ST_IDLE);
  assign done = io_dmem_request_valid && io_dmem_response_valid;

  always_comb begin
    misaligned = 1'b0;
    unique case (1'b1)
      is_word(size_q):    misaligned = (addr_q[1:0] != 2'b00);
      (size_q == SZ_HALF): misaligned = addr_q[0];
      default: ;
    endcase
  end

  lsu_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .word  (io_dmem_response_bits_data),
    .wdata (wdata_q),
    .off   (addr_q[1:0]),
    .size  (size_q),
    .sign  (sign_q),
    .ext   (ext),
    .merged(merged)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                          <= ST_IDLE;
      addr_q                         <= '0;
      wdata_q                        <= '0;
      size_q                         <= '0;
      store_q                        <= 1'b0;
      sign_q                         <= 1'b0;
      io_resp_valid                  <= 1'b0;
      io_resp_data                   <= '0;
      io_resp_misaligned             <= 1'b0;
      io_dmem_request_valid          <= 1'b0;
      io_dmem_request_bits_address   <= '0;
      io_dmem_request_bits_writedata <= '0;
      io_dmem_request_bits_operation <= MEM_OP_READ;
    end else begin
      io_resp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (io_req_valid) begin
            addr_q  <= io_req_addr;
            wdata_q <= io_req_wdata;
            size_q  <= io_req_size;
            store_q <= io_req_is_store;
            sign_q  <= io_req_sign_ext;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (misaligned) begin
            io_resp_valid      <= 1'b1;
            io_resp_misaligned <= 1'b1;
            io_resp_data       <= '0;
            state              <= ST_RESP;
          end else begin
            io_dmem_request_valid        <= 1'b1;
            io_dmem_request_bits_address <= {addr32[31:2], 2'b00};
            if (!store_q) begin
              io_dmem_request_bits_operation <= MEM_OP_READ;
              state                          <= ST_LOAD;
            end else if (is_word(size_q)) begin
              io_dmem_request_bits_operation <= MEM_OP_WRITE;
              io_dmem_request_bits_writedata <= wdata_q;
              state                          <= ST_STORE;
            end else begin
              io_dmem_request_bits_operation <= MEM_OP_READ;
              state                          <= ST_RMW_RD;
            end
          end
        end
        ST_LOAD: begin
          if (done) begin
            io_dmem_request_valid <= 1'b0;
            io_resp_valid         <= 1'b1;
            io_resp_misaligned    <= 1'b0;
            io_resp_data          <= ext;
            state                 <= ST_RESP;
          end
        end
        ST_RMW_RD: begin
          // Request stays valid: the read turns straight into the write.
          if (done) begin
            io_dmem_request_bits_writedata <= merged;
            io_dmem_request_bits_operation <= MEM_OP_WRITE;
            state                          <= ST_RMW_WR;
          end
        end
        ST_STORE, ST_RMW_WR: begin
          if (done) begin
            io_dmem_request_valid <= 1'b0;
            io_resp_valid         <= 1'b1;
            io_resp_misaligned    <= 1'b0;
            io_resp_data          <= '0;
            state                 <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_adapter.sv
// Scoreboard bench for dmem_lsu_adapter: directed loads/stores
// against a simple word memory with programmable response delay.
module tb_dmem_lsu_adapter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_sign = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_mis;
  logic        dm_valid;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [1:0]  dm_op;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  dmem_lsu_adapter dut (
    .clock                         (clock),
    .reset                         (reset),
    .io_req_valid                  (req_valid),
    .io_req_ready                  (req_ready),
    .io_req_addr                   (req_addr),
    .io_req_wdata                  (req_wdata),
    .io_req_is_store               (req_store),
    .io_req_size                   (req_size),
    .io_req_sign_ext               (req_sign),
    .io_resp_valid                 (resp_valid),
    .io_resp_data                  (resp_data),
    .io_resp_misaligned            (resp_mis),
    .io_dmem_request_valid         (dm_valid),
    .io_dmem_request_bits_address  (dm_addr),
    .io_dmem_request_bits_writedata(dm_wdata),
    .io_dmem_request_bits_operation(dm_op),
    .io_dmem_response_valid        (dm_rvalid),
    .io_dmem_response_bits_data    (dm_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dop_t;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    int          acc;
    int          lat;
  } rsp_t;

  dop_t dq[$];
  rsp_t rq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int delay = 0;
  int wcnt = 0;
  int dm_cycles = 0;
  int resp_count = 0;
  logic [31:0] mem [0:255];

  logic        hold = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic [1:0]  h_op;

  assign dm_rvalid = dm_valid && (wcnt == delay);
  assign dm_rdata  = mem[dm_addr[9:2]];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset || !dm_valid || dm_rvalid) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: dmem transactions and adapter responses.
  always @(negedge clock) begin
    if (!reset) begin
      hold = 1'b0;
    end else begin
      if (dm_valid) begin
        dm_cycles++;
        if (hold) begin
          chk("hold_addr", dm_addr, h_addr);
          chk("hold_op", {30'd0, dm_op}, {30'd0, h_op});
          chk("hold_wdata", dm_wdata, h_wdata);
        end
        if (dm_rvalid) begin
          hold = 1'b0;
          if (dq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_dmem: op %0d addr %h", dm_op, dm_addr);
          end else begin
            dop_t e;
            e = dq.pop_front();
            chk("dmem_op", {30'd0, dm_op}, {30'd0, e.op});
            chk("dmem_addr", dm_addr, e.addr);
            if (e.op == 2'd1) chk("dmem_wdata", dm_wdata, e.wdata);
          end
          if (dm_op == 2'd1) mem[dm_addr[9:2]] = dm_wdata;
        end else begin
          hold = 1'b1;
          h_addr = dm_addr; h_wdata = dm_wdata; h_op = dm_op;
        end
      end else begin
        hold = 1'b0;
      end
      if (resp_valid) begin
        resp_count++;
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: data %h mis %b", resp_data, resp_mis);
        end else begin
          rsp_t r;
          r = rq.pop_front();
          chk("resp_data", resp_data, r.data);
          chk("resp_mis", {31'd0, resp_mis}, {31'd0, r.mis});
          chk("latency", 32'(cyc - r.acc), 32'(r.lat));
        end
      end
    end
  end

  task automatic push_op(logic [1:0] op, logic [31:0] a, logic [31:0] d);
    dop_t e;
    e.op = op; e.addr = a; e.wdata = d;
    dq.push_back(e);
  endtask

  task automatic drive(logic [31:0] a, logic [31:0] d, logic st,
                       logic [1:0] sz, logic sg);
    @(posedge clock); #1;
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = a; req_wdata = d;
    req_store = st; req_size = sz; req_sign = sg;
  endtask

  task automatic issue(logic [31:0] a, logic [31:0] d, logic st,
                       logic [1:0] sz, logic sg, logic [31:0] ed,
                       logic em, int lat);
    rsp_t r;
    drive(a, d, st, sz, sg);
    r.data = ed; r.mis = em; r.acc = cyc; r.lat = lat;
    rq.push_back(r);
    @(posedge clock); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 40 && rq.size() != 0; i++) @(posedge clock);
    if (rq.size() != 0) begin
      tests++; fails++;
      $display("FAIL resp_timeout: %0d pending, required 0", rq.size());
      rq.delete();
    end
    if (dq.size() != 0) begin
      tests++; fails++;
      $display("FAIL dmem_missing: %0d pending, required 0", dq.size());
      dq.delete();
    end
  endtask

  initial begin
    int snap;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    reset = 1'b1;

    // Loads from 0x80FF_1234 at 0x100
    mem[8'h40] = 32'h80FF_1234;
    push_op(2'd0, 32'h100, 0);
    issue(32'h103, 0, 0, 2'd0, 1, 32'hFFFF_FF80, 0, 3);
    push_op(2'd0, 32'h100, 0);
    issue(32'h102, 0, 0, 2'd1, 0, 32'h0000_80FF, 0, 3);
    push_op(2'd0, 32'h100, 0);
    issue(32'h102, 0, 0, 2'd1, 1, 32'hFFFF_80FF, 0, 3);
    push_op(2'd0, 32'h100, 0);
    issue(32'h101, 0, 0, 2'd0, 1, 32'h0000_0012, 0, 3);
    push_op(2'd0, 32'h100, 0);
    issue(32'h103, 0, 0, 2'd0, 0, 32'h0000_0080, 0, 3);
    push_op(2'd0, 32'h100, 0);
    issue(32'h100, 0, 0, 2'd1, 1, 32'h0000_1234, 0, 3);

    // Sub-word stores via read-modify-write
    mem[8'h40] = 32'h1122_3344;
    push_op(2'd0, 32'h100, 0);
    push_op(2'd1, 32'h100, 32'h1122_AB44);
    issue(32'h101, 32'hFFFF_FFAB, 1, 2'd0, 0, 32'h0, 0, 4);
    chk("mem_sb", mem[8'h40], 32'h1122_AB44);
    push_op(2'd0, 32'h100, 0);
    push_op(2'd1, 32'h100, 32'hCAFE_AB44);
    issue(32'h102, 32'h1234_CAFE, 1, 2'd1, 0, 32'h0, 0, 4);
    chk("mem_sh", mem[8'h40], 32'hCAFE_AB44);
    push_op(2'd0, 32'h100, 0);
    issue(32'h100, 0, 0, 2'd3, 0, 32'hCAFE_AB44, 0, 3);

    // Misaligned accesses never reach dmem
    snap = dm_cycles;
    issue(32'h102, 0, 0, 2'd2, 0, 32'h0, 1, 2);
    issue(32'h101, 0, 0, 2'd1, 1, 32'h0, 1, 2);
    issue(32'h203, 32'h5555_5555, 1, 2'd2, 0, 32'h0, 1, 2);
    chk("mis_no_dmem", 32'(dm_cycles), 32'(snap));
    chk("mis_no_write", mem[8'h80], 32'h0);

    // Word store with a slow memory
    delay = 3;
    push_op(2'd1, 32'h200, 32'hDEAD_BEEF);
    issue(32'h200, 32'hDEAD_BEEF, 1, 2'd2, 0, 32'h0, 0, 6);
    chk("mem_sw", mem[8'h80], 32'hDEAD_BEEF);

    // Reset while the RMW write is outstanding
    delay = 2;
    mem[8'h40] = 32'h1122_3344;
    push_op(2'd0, 32'h100, 0);
    push_op(2'd1, 32'h100, 32'h1155_3344);
    drive(32'h102, 32'h55, 1, 2'd0, 0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 30 && !(dm_valid && dm_op == 2'd1); i++)
      @(negedge clock);
    chk("reach_rmw_wr", {30'd0, dm_op}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_dm_valid", {31'd0, dm_valid}, 32'd0);
    chk("arst_dm_addr", dm_addr, 32'd0);
    chk("arst_dm_op", {30'd0, dm_op}, 32'd0);
    chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    dq.delete();
    snap = resp_count;
    @(negedge clock);
    reset = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    chk("no_resp_after_rst", 32'(resp_count), 32'(snap));
    chk("rmw_abandoned", mem[8'h40], 32'h1122_3344);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    delay = 0;
    push_op(2'd0, 32'h100, 0);
    issue(32'h102, 0, 0, 2'd0, 0, 32'h0000_0022, 0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
